rsa_job_scheduler: RTL
======================

# rsa_job_scheduler

Shares one RSA accelerator between `NUM_REQ` requesters, for example a CPU port and a DMA port. Each requester submits a job as one valid/ready transfer carrying key, modulus and message. The block arbitrates round-robin, loads the operands into the accelerator, pulses start and watches the accelerator's idle flag. It then returns the result or an error to the granted requester over a per-requester response handshake.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2–8).
- `KEY_SIZE_BITS`, 16: operand width; must match the accelerator.
- `TIMEOUT_CYCLES`, 1024: watchdog limit, used only when `RSA_SCHED_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: job offered by requester i.
- `req_ready` out NUM_REQ: one-hot, asserted for exactly the cycle requester i's job is accepted.
- `req_key` in NUM_REQ*K: exponent for requester i, in slice i.
- `req_mod` in NUM_REQ*K: modulus for requester i, in slice i.
- `req_msg` in NUM_REQ*K: message block for requester i, in slice i.
- `resp_valid` out NUM_REQ: one-hot, response pending for requester i.
- `resp_ready` in NUM_REQ: requester i accepts its response.
- `resp_data` out K: result; 0 when an error is reported.
- `resp_err` out 1: job failed (modulus 0, or timeout).
- `acc_start` out 1: to accelerator `RSA_start`.
- `acc_key` out K: to accelerator `RSA_key`.
- `acc_mod` out K: to accelerator `mod_n`.
- `acc_msg` out K: to accelerator `msg_block`.
- `acc_upd_key` out 1: to accelerator `update_key_from_mem`.
- `acc_upd_mod` out 1: to accelerator `update_mod_n`.
- `acc_upd_msg` out 1: to accelerator `update_msg_blk`.
- `acc_result` in K: from accelerator `o_output_msg`.
- `acc_idle` in 1: from accelerator `o_idle_flag`, which is registered.

## Operation
States: IDLE, LOAD, START, WAIT_LO, WAIT_HI, RESP, DRAIN.

- **IDLE**
  - Arbitration happens only when `acc_idle`=1 and at least one `req_valid` is high.
  - The round-robin pointer selects the first valid requester after the last one granted; after reset, requester 0 has top priority.
  - The granted requester gets `req_ready`, and its key, modulus, message and index are captured.
  - If the captured modulus is 0, go to RESP with `resp_err`=1 and `resp_data`=0; the accelerator is not touched.
  - Otherwise go to LOAD.
- **LOAD**: drive the captured operands on `acc_key`/`acc_mod`/`acc_msg`; assert all three `acc_upd_*` for this one cycle; go to START.
- **START**: pulse `acc_start` for one cycle; clear the watchdog; go to WAIT_LO.
- **WAIT_LO**: wait for `acc_idle`=0, which is expected on the cycle after START; then go to WAIT_HI.
- **WAIT_HI**: when `acc_idle`=1, capture `acc_result` into `resp_data` with `resp_err`=0; go to RESP.
- **RESP**
  - Hold `resp_valid[idx]` and the data until `resp_ready[idx]`.
  - Then advance the pointer to idx and return to IDLE.
  - `resp_ready` of any other requester is ignored.
- **DRAIN** (timeout only): wait for `acc_idle`=1, then go to RESP with the error response already latched.

Rules:
- `acc_upd_*` and `acc_start` are never asserted in the same cycle.
- `acc_upd_*` is asserted only while `acc_idle`=1.
- Exponent 0 is legal; the accelerator returns 1.
- A requester that drops `req_valid` before it is granted is simply skipped.
- Requests arriving while a job is running wait; there is no queue beyond the requesters' own valid signals.

## Timing
Reset values:
- All outputs are 0.
- State is IDLE; pointer is at requester 0; watchdog is 0.

Latency:
- From grant (the `req_ready` cycle) to `acc_start` is 2 cycles.
- From `acc_idle` rising in WAIT_HI to `resp_valid` is 1 cycle.
- A modulus-0 error reaches `resp_valid` 1 cycle after grant.

Other timing rules:
- If `acc_idle` is still 0 on the first cycle after reset, IDLE waits; no grant is made.
- The response takes ≥1 cycle; a new grant can happen no earlier than the cycle after the response handshake.
- Reset mid-job drops the job without any response. The accelerator shares the system reset.

## Configuration
Macro `RSA_SCHED_TIMEOUT_EN`.
- **Defined**:
  - A counter runs in WAIT_LO and WAIT_HI.
  - When it reaches `TIMEOUT_CYCLES` without completion, latch `resp_err`=1 and `resp_data`=0, then go to DRAIN.
  - Any late `acc_result` is discarded.
- **Undefined**: no counter; WAIT_LO and WAIT_HI wait indefinitely; the DRAIN state is not reachable.

## Structure
- Package `rsa_sched_pkg`: state enum `rsa_sched_state_e`; localparam for the watchdog counter width, `$clog2(TIMEOUT_CYCLES+1)`.
- Sub-module `rsa_rr_arbiter`: combinational one-hot round-robin grant from `req_valid` and the pointer. The pointer register stays in the top module.

## Test plan
- **Single job:** requester 0 sends msg=5, key=3, mod=13. Expect `acc_start` 2 cycles after grant, then `resp_valid[0]`, `resp_data`=8, `resp_err`=0.
- **Exponent 0:** requester 1 sends msg=7, key=0, mod=11. Expect `resp_data`=1.
- **Modulus 0:** requester 0 sends mod=0. Expect `resp_err`=1 and `resp_data`=0 one cycle after grant, with no `acc_upd_*` or `acc_start` pulse.
- **Round-robin:** both requesters hold `req_valid` continuously for 4 jobs. Expect grant order 0,1,0,1 and `resp_valid` never asserted for two requesters at once.
- **Backpressure:** hold `resp_ready[1]`=0 for 20 cycles. Expect `resp_data` stable and no new grant until the handshake.
- **Timeout** (`RSA_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, accelerator stub holds `acc_idle` low):
  - Expect `resp_err`=1 only after the stub raises `acc_idle`.
  - Reset asserted during WAIT_HI returns all outputs to 0 and state to IDLE.

Source files
------------

// File: rtl/rsa_sched_pkg.sv
// Shared types for rsa_job_scheduler: FSM state encoding and watchdog sizing.
// The watchdog only exists when RSA_SCHED_TIMEOUT_EN is defined.
package rsa_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RESP,
    S_DRAIN
  } rsa_sched_state_e;

  localparam int TIMEOUT_CYCLES_DFLT = 1024;
  localparam int WDOG_W              = $clog2(TIMEOUT_CYCLES_DFLT + 1);

  function automatic int wdog_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester at or after the top-priority index `ptr`.
module rsa_rr_arbiter
  import rsa_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Round-robin scheduler sharing one RSA accelerator among NUM_REQ requesters.
// Define RSA_SCHED_TIMEOUT_EN to add a watchdog with error response and DRAIN.
module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int KEY_SIZE_BITS  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*KEY_SIZE_BITS-1:0] req_key,
  input  logic [NUM_REQ*KEY_SIZE_BITS-1:0] req_mod,
  input  logic [NUM_REQ*KEY_SIZE_BITS-1:0] req_msg,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [KEY_SIZE_BITS-1:0]   resp_data,
  output logic                       resp_err,
  output logic                       acc_start,
  output logic [KEY_SIZE_BITS-1:0]   acc_key,
  output logic [KEY_SIZE_BITS-1:0]   acc_mod,
  output logic [KEY_SIZE_BITS-1:0]   acc_msg,
  output logic                       acc_upd_key,
  output logic                       acc_upd_mod,
  output logic                       acc_upd_msg,
  input  logic [KEY_SIZE_BITS-1:0]   acc_result,
  input  logic                       acc_idle
);

  localparam int K     = KEY_SIZE_BITS;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rsa_job_scheduler: unsupported parameter set");
  end

  rsa_sched_state_e   state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;   // index of the requester with top priority
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [K-1:0]       key_q, key_d, mod_q, mod_d, msg_q, msg_d;
  logic [K-1:0]       data_q, data_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [K-1:0]       sel_mod;

  rsa_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_mod = req_mod[int'(grant_idx)*K +: K];

`ifdef RSA_SCHED_TIMEOUT_EN
  localparam int WD_W = wdog_width(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_hit;
  assign wdog_hit = (wdog_q == WD_W'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    key_d       = key_q;
    mod_d       = mod_q;
    msg_d       = msg_q;
    data_d      = data_q;
    err_d       = err_q;
    req_ready   = '0;
    resp_valid  = '0;
    acc_start   = 1'b0;
    acc_upd_key = 1'b0;
    acc_upd_mod = 1'b0;
    acc_upd_msg = 1'b0;
    acc_key     = '0;
    acc_mod     = '0;
    acc_msg     = '0;
`ifdef RSA_SCHED_TIMEOUT_EN
    // Saturates so the compare stays valid for any TIMEOUT_CYCLES.
    wdog_d = wdog_hit ? wdog_q : wdog_q + 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (acc_idle && |req_valid) begin
          req_ready = grant;
          idx_d     = grant_idx;
          key_d     = req_key[int'(grant_idx)*K +: K];
          mod_d     = sel_mod;
          msg_d     = req_msg[int'(grant_idx)*K +: K];
          if (sel_mod == '0) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        acc_key     = key_q;
        acc_mod     = mod_q;
        acc_msg     = msg_q;
        acc_upd_key = 1'b1;
        acc_upd_mod = 1'b1;
        acc_upd_msg = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        acc_start = 1'b1;
`ifdef RSA_SCHED_TIMEOUT_EN
        wdog_d    = '0;
`endif
        state_d   = S_WAIT_LO;
      end
      S_WAIT_LO: begin
`ifdef RSA_SCHED_TIMEOUT_EN
        if (wdog_hit) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_DRAIN;
        end else
`endif
        if (!acc_idle) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (acc_idle) begin
          data_d  = acc_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef RSA_SCHED_TIMEOUT_EN
        else if (wdog_hit) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_DRAIN;
        end
`endif
      end
      S_RESP: begin
        resp_valid[idx_q] = 1'b1;
        if (resp_ready[idx_q]) begin
          ptr_d   = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Error already latched; the late result is never sampled.
        if (acc_idle) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_data = (state_q == S_RESP) ? data_q : '0;
  assign resp_err  = (state_q == S_RESP) ? err_q  : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      mod_q   <= '0;
      msg_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef RSA_SCHED_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      mod_q   <= mod_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef RSA_SCHED_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

endmodule
